// File: rtl/bp_nonsynth_trace_replay_mc_if.sv
// Send/recv channel bundle between the replay engine (master) and the bench (slave).
interface bp_nonsynth_trace_replay_mc_if #(
  parameter int channels_p      = 2,
  parameter int payload_width_p = 64
);
  logic [channels_p-1:0]                      send_v;
  logic [payload_width_p-1:0]                 send_data;
  logic [channels_p-1:0]                      send_yumi;
  logic [channels_p-1:0]                      recv_v;
  logic [channels_p-1:0][payload_width_p-1:0] recv_data;
  logic [channels_p-1:0]                      recv_ready_and;

  modport master (output send_v, send_data, recv_ready_and,
                  input  send_yumi, recv_v, recv_data);
  modport slave  (input  send_v, send_data, recv_ready_and,
                  output send_yumi, recv_v, recv_data);
endinterface

// File: rtl/bp_nonsynth_trace_replay_mc.sv
// Multi-channel trace replay: walks a combinational ROM of command words,
// issuing sends, checking receives (optionally masked), waiting, and
// flagging mismatches / illegal ops / stall timeouts with sticky status.
module bp_nonsynth_trace_replay_mc #(
  parameter  int payload_width_p   = 64,
  parameter  int rom_addr_width_p  = 10,
  parameter  int channels_p        = 2,
  parameter  int timeout_p         = 4096,
  parameter  int err_count_width_p = 16,
  localparam int ch_w  = (channels_p > 1) ? $clog2(channels_p) : 1,
  localparam int rom_w = 4 + ch_w + 1 + payload_width_p
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         en_i,
  output logic [rom_addr_width_p-1:0]  rom_addr_o,
  input  logic [rom_w-1:0]             rom_data_i,
  bp_nonsynth_trace_replay_mc_if.master bus_io,
  output logic                         done_o,
  output logic                         error_o,
  output logic                         timeout_o,
  output logic [err_count_width_p-1:0] err_count_o
);

  localparam int STALL_W = (timeout_p > 1) ? $clog2(timeout_p + 1) : 1;
  localparam logic [3:0] OP_NOP = 4'd0, OP_SEND = 4'd1, OP_RECV = 4'd2,
                         OP_WAIT = 4'd3, OP_DONE = 4'd4;

  typedef enum logic [2:0] {eRun, eMask, eWait, eDone, eHalt} state_e;

  state_e                       state_q, state_d;
  logic [rom_addr_width_p-1:0]  pc_q, pc_d;
  logic [15:0]                  wait_q, wait_d;
  logic [STALL_W-1:0]           stall_q, stall_d;
  logic [payload_width_p-1:0]   exp_q, exp_d;
  logic [ch_w-1:0]              ch_q, ch_d;
  logic                         done_q, done_d, error_q, error_d, timeout_q, timeout_d;
  logic [err_count_width_p-1:0] errcnt_q, errcnt_d;

  // ROM word fields
  logic [payload_width_p-1:0] payload;
  logic                       mask_en;
  logic [ch_w-1:0]            ch;
  logic [3:0]                 op;
  logic [4:0]                 ch_ext;
  logic                       legal;
  assign payload = rom_data_i[payload_width_p-1:0];
  assign mask_en = rom_data_i[payload_width_p];
  assign ch      = rom_data_i[payload_width_p+1 +: ch_w];
  assign op      = rom_data_i[payload_width_p+1+ch_w +: 4];
  assign ch_ext  = 5'(ch);
  // Out-of-range channels only matter for ops that touch a channel
  assign legal   = (op <= OP_DONE) &&
                   !(((op == OP_SEND) || (op == OP_RECV)) && (ch_ext >= 5'(channels_p)));

  logic adv, stall, bump;

  // State register: all engine state, asynchronously cleared
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= eRun;
      pc_q      <= '0;
      wait_q    <= '0;
      stall_q   <= '0;
      exp_q     <= '0;
      ch_q      <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      errcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      wait_q    <= wait_d;
      stall_q   <= stall_d;
      exp_q     <= exp_d;
      ch_q      <= ch_d;
      done_q    <= done_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
      errcnt_q  <= errcnt_d;
    end
  end

  // Next state: decode, handshake completion, stall timeout, error counting
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wait_d    = wait_q;
    stall_d   = stall_q;
    exp_d     = exp_q;
    ch_d      = ch_q;
    done_d    = done_q;
    error_d   = error_q;
    timeout_d = timeout_q;
    errcnt_d  = errcnt_q;
    adv       = 1'b0;
    stall     = 1'b0;
    bump      = 1'b0;
    if (en_i) begin
      case (state_q)
        eRun: begin
          if (!legal) begin
            bump = 1'b1;
            adv  = 1'b1;
          end else begin
            case (op)
              OP_NOP:  adv = 1'b1;
              OP_SEND: if (bus_io.send_yumi[ch]) adv = 1'b1; else stall = 1'b1;
              OP_RECV: begin
                if (mask_en) begin
                  // PC steps onto the mask word; the compare happens in eMask
                  exp_d   = payload;
                  ch_d    = ch;
                  state_d = eMask;
                  adv     = 1'b1;
                end else if (bus_io.recv_v[ch]) begin
                  adv  = 1'b1;
                  bump = |(bus_io.recv_data[ch] ^ payload);
                end else begin
                  stall = 1'b1;
                end
              end
              OP_WAIT: begin
                if (payload[15:0] == 16'd0) adv = 1'b1;
                else begin
                  wait_d  = payload[15:0];
                  state_d = eWait;
                end
              end
              OP_DONE: begin
                state_d = eDone;
                done_d  = 1'b1;
              end
              default: ;
            endcase
          end
        end
        eMask: begin
          if (bus_io.recv_v[ch_q]) begin
            adv     = 1'b1;
            state_d = eRun;
            bump    = |((bus_io.recv_data[ch_q] ^ exp_q) & payload);
          end else begin
            stall = 1'b1;
          end
        end
        eWait: begin
          wait_d = wait_q - 1'b1;
          if (wait_q == 16'd1) begin
            adv     = 1'b1;
            state_d = eRun;
          end
        end
        default: ;
      endcase
    end
    if (adv) begin
      pc_d    = pc_q + 1'b1;
      stall_d = '0;
    end else if (stall) begin
      stall_d = stall_q + 1'b1;
      if ((timeout_p != 0) && (stall_d == STALL_W'(timeout_p))) begin
        state_d   = eHalt;
        timeout_d = 1'b1;
        error_d   = 1'b1;
      end
    end
    if (bump) begin
      error_d = 1'b1;
      if (~&errcnt_q) errcnt_d = errcnt_q + 1'b1;
    end
  end

  // Outputs: one-hot valid/ready straight from state + current ROM word
  always_comb begin
    bus_io.send_v         = '0;
    bus_io.send_data      = '0;
    bus_io.recv_ready_and = '0;
    if (en_i && !reset_i) begin
      case (state_q)
        eRun: begin
          if (legal && (op == OP_SEND)) begin
            bus_io.send_v[ch] = 1'b1;
            bus_io.send_data  = payload;
          end
          if (legal && (op == OP_RECV) && !mask_en) bus_io.recv_ready_and[ch] = 1'b1;
        end
        eMask:   bus_io.recv_ready_and[ch_q] = 1'b1;
        default: ;
      endcase
    end
  end

  assign rom_addr_o  = pc_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign timeout_o   = timeout_q;
  assign err_count_o = errcnt_q;

endmodule
